// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a CPU write to the DMA register copies XFER_LEN bytes from
// page {value,8'h00} (echo-RAM pages E0..FF folded down by 8'h20) into OAM.
// Every output except cpu_rdata is a register. Each one is loaded from the
// next-state values, so the strobes line up exactly with the slot counter.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46,
  parameter logic [15:0] OAM_BASE        = 16'hFE00,
  parameter int          XFER_LEN        = 160,
  parameter int          CYCLES_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_rdata,
  output logic [15:0] oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr,
  output logic        busy
);

  localparam int CW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so pages E0 and above fold down by 8'h20.
  function automatic logic [7:0] echo_page(input logic [7:0] value);
    if (value >= 8'hE0) begin
      echo_page = value - 8'h20;
    end else begin
      echo_page = value;
    end
  endfunction

  state_t          state_r, state_s;
  logic [7:0]      dma_reg_r, dma_reg_s;
  logic [7:0]      page_r, page_s;
  logic [7:0]      idx_r, idx_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            trigger_s;
  logic            slot_end_s;
  logic            src_rd_s, oam_wr_s, busy_s;
  logic [15:0]     src_addr_s, oam_addr_s;
  logic [7:0]      oam_wdata_s;

  // Next-state logic: slot sequencing first, then a trigger write overrides everything (restart).
  always_comb begin
    state_s    = state_r;
    dma_reg_s  = dma_reg_r;
    page_s     = page_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    trigger_s  = cpu_wr && (cpu_addr == DMA_REG_ADDR);
    slot_end_s = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        cnt_s = CW'(0);
        idx_s = 8'd0;
      end
      START: begin
        if (slot_end_s) begin
          state_s = XFER;
          cnt_s   = CW'(0);
          idx_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      XFER: begin
        if (slot_end_s) begin
          cnt_s = CW'(0);
          if (idx_r == IDX_LAST) begin
            state_s = IDLE;
            idx_s   = 8'd0;
          end else begin
            idx_s = idx_r + 8'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CW'(0);
        idx_s   = 8'd0;
      end
    endcase
    if (trigger_s) begin
      state_s   = START;
      cnt_s     = CW'(0);
      idx_s     = 8'd0;
      dma_reg_s = cpu_wdata;
      page_s    = echo_page(cpu_wdata);
    end else begin
      dma_reg_s = dma_reg_r;
    end
  end

  // Output decode from the next state, so each registered strobe is visible during its own slot clock.
  always_comb begin
    src_rd_s    = (state_s == XFER) && (cnt_s == CW'(0));
    oam_wr_s    = (state_s == XFER) && (cnt_s == CW'(2));
    busy_s      = (state_s != IDLE);
    src_addr_s  = src_addr;
    oam_addr_s  = oam_addr;
    oam_wdata_s = oam_wdata;
    if (src_rd_s) begin
      src_addr_s = {page_s, 8'h00} + {8'h00, idx_s};
    end else begin
      src_addr_s = src_addr;
    end
    if (oam_wr_s) begin
      oam_addr_s = OAM_BASE + {8'h00, idx_s};
    end else begin
      oam_addr_s = oam_addr;
    end
    // Source data is valid during the c=1 clock; it is held here and written out at c=2.
    if ((state_r == XFER) && (cnt_r == CW'(1))) begin
      oam_wdata_s = src_rdata;
    end else begin
      oam_wdata_s = oam_wdata;
    end
  end

  // State, bookkeeping and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      dma_reg_r <= 8'h00;
      page_r    <= 8'h00;
      idx_r     <= 8'd0;
      cnt_r     <= CW'(0);
      src_rd    <= 1'b0;
      oam_wr    <= 1'b0;
      busy      <= 1'b0;
      src_addr  <= 16'h0000;
      oam_addr  <= 16'h0000;
      oam_wdata <= 8'h00;
    end else begin
      state_r   <= state_s;
      dma_reg_r <= dma_reg_s;
      page_r    <= page_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      src_rd    <= src_rd_s;
      oam_wr    <= oam_wr_s;
      busy      <= busy_s;
      src_addr  <= src_addr_s;
      oam_addr  <= oam_addr_s;
      oam_wdata <= oam_wdata_s;
    end
  end

  // Register readback; reads of any other address return zero.
  always_comb begin
    if (cpu_rd && (cpu_addr == DMA_REG_ADDR)) begin
      cpu_rdata = dma_reg_r;
    end else begin
      cpu_rdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: three instances (4, 3 and 8 clocks per byte)
// share the CPU stimulus. A cycle-arithmetic model of the latest trigger
// predicts busy, the strobes, the addresses and the data on every cycle.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        chk_en;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  // model state: only the most recent trigger matters
  int         cyc = 0;
  int         trig = 0;
  bit         active = 1'b0;
  logic [7:0] reg_exp = 8'h00;
  logic [7:0] page_exp = 8'h00;

  int         wr_cnt [3];
  int         rd_cnt [3];
  int         busy_cnt [3];
  int         first_rd [3];
  logic [15:0] first_src_addr, last_src_addr;
  logic [7:0] prev_rdata [3];
  logic [7:0] oam0 [0:159];

  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : u
    localparam int CPB = (gi == 0) ? 4 : ((gi == 1) ? 3 : 8);
    logic [7:0]  rdata, src_rdata, oam_wdata;
    logic [15:0] src_addr, oam_addr;
    logic        src_rd, oam_wr, busy;

    oam_dma_controller #(.CYCLES_PER_BYTE(CPB)) dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(rdata),
      .src_addr(src_addr), .src_rd(src_rd), .src_rdata(src_rdata),
      .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_wr(oam_wr), .busy(busy)
    );

    // system memory: data valid one clock after src_rd, garbage otherwise
    always @(posedge clk) begin
      if (src_rd) src_rdata <= mem[src_addr];
      else        src_rdata <= 8'($urandom);
    end
  end

  task automatic cmp(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h, expected %h (cycle %0d)", name, g, act, exp, cyc);
    end
  endtask

  // model update: count edges and remember the latest trigger write
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active  = 1'b0;
      reg_exp = 8'h00;
    end else begin
      cyc++;
      if (cpu_wr && cpu_addr == 16'hFF46) begin
        active   = 1'b1;
        trig     = cyc;
        reg_exp  = cpu_wdata;
        page_exp = (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
      end
    end
  end

  task automatic check_inst(input int g, input int cpb, input logic busy, input logic src_rd,
                            input logic [15:0] src_addr, input logic oam_wr, input logic [15:0] oam_addr,
                            input logic [7:0] oam_wdata, input logic [7:0] src_rdata);
    int rel, s, k, c;
    logic eb, er, ew;
    logic [15:0] a;
    eb = 1'b0; er = 1'b0; ew = 1'b0; k = 0;
    if (active) begin
      rel = cyc - trig;                 // 0 on the clock right after the trigger edge
      eb  = (rel < 161 * cpb);
      s   = rel - cpb;                  // one empty slot before byte 0
      if (s >= 0 && s < 160 * cpb) begin
        k  = s / cpb;
        c  = s % cpb;
        er = (c == 0);
        ew = (c == 2);
      end
    end
    a = {page_exp, 8'h00} + 16'(k);
    cmp("busy", g, 32'(busy), 32'(eb));
    cmp("src_rd", g, 32'(src_rd), 32'(er));
    cmp("oam_wr", g, 32'(oam_wr), 32'(ew));
    cmp("rd_wr_overlap", g, 32'(src_rd & oam_wr), 32'd0);
    if (er) cmp("src_addr", g, 32'(src_addr), 32'(a));
    if (ew) begin
      cmp("oam_addr", g, 32'(oam_addr), 32'(16'hFE00 + 16'(k)));
      cmp("oam_wdata", g, 32'(oam_wdata), 32'(mem[a]));
      cmp("wdata_vs_read", g, 32'(oam_wdata), 32'(prev_rdata[g]));
    end
    if (src_rd) begin
      rd_cnt[g]++;
      if (first_rd[g] < 0) first_rd[g] = cyc;
      if (g == 0) begin
        if (rd_cnt[0] == 1) first_src_addr = src_addr;
        last_src_addr = src_addr;
      end
    end
    if (oam_wr) begin
      wr_cnt[g]++;
      if (g == 0 && oam_addr >= 16'hFE00 && oam_addr < 16'hFEA0) oam0[oam_addr - 16'hFE00] = oam_wdata;
    end
    if (busy) busy_cnt[g]++;
    prev_rdata[g] = src_rdata;
  endtask

  // single compare process: every cycle outside reset
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check_inst(0, 4, u[0].busy, u[0].src_rd, u[0].src_addr, u[0].oam_wr, u[0].oam_addr, u[0].oam_wdata, u[0].src_rdata);
      check_inst(1, 3, u[1].busy, u[1].src_rd, u[1].src_addr, u[1].oam_wr, u[1].oam_addr, u[1].oam_wdata, u[1].src_rdata);
      check_inst(2, 8, u[2].busy, u[2].src_rd, u[2].src_addr, u[2].oam_wr, u[2].oam_addr, u[2].oam_wdata, u[2].src_rdata);
    end
  end

  task automatic clear_counts();
    for (int g = 0; g < 3; g++) begin
      wr_cnt[g] = 0; rd_cnt[g] = 0; busy_cnt[g] = 0; first_rd[g] = -1;
    end
  endtask

  // drive a CPU write for one clock, starting at the current negedge
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wr    = 1'b1;
    @(negedge clk);
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h0000;
  endtask

  task automatic cpu_read_check(input logic [7:0] exp);
    cpu_rd   = 1'b1;
    cpu_addr = 16'hFF46;
    #1;
    cmp("readback", 0, 32'(u[0].rdata), 32'(exp));
    cmp("readback", 1, 32'(u[1].rdata), 32'(exp));
    cmp("readback", 2, 32'(u[2].rdata), 32'(exp));
    cpu_addr = 16'hFF45;
    #1;
    cmp("read_other_addr", 0, 32'(u[0].rdata), 32'd0);
    cpu_rd   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!u[0].busy && !u[1].busy && !u[2].busy) break;
      @(negedge clk);
    end
    cmp("idle_timeout", 0, 32'(i < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt[0] >= n) break;
    end
    cmp("write_wait_timeout", 0, 32'(i < budget), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [8];
    vals = '{8'hC0, 8'hC1, 8'hD5, 8'hE3, 8'hF1, 8'hFE, 8'h80, 8'h00};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hD000 + 16'(i)] = 8'(i) + 8'h30;
    end
    reset = 1'b1; chk_en = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    cmp("reset_busy", 0, 32'(u[0].busy), 32'd0);
    cmp("reset_src_addr", 0, 32'(u[0].src_addr), 32'd0);
    cmp("reset_oam_addr", 0, 32'(u[0].oam_addr), 32'd0);
    cmp("reset_strobes", 0, 32'({u[0].src_rd, u[0].oam_wr}), 32'd0);
    reset = 1'b0; chk_en = 1'b1;
    repeat (3) @(negedge clk);
    cpu_read_check(8'h00);

    // basic copy from C0xx
    clear_counts();
    cpu_write(16'hFF46, 8'hC0);
    wait_idle(3000);
    cmp("busy_len", 0, 32'(busy_cnt[0]), 32'd644);
    cmp("busy_len", 1, 32'(busy_cnt[1]), 32'd483);
    cmp("busy_len", 2, 32'(busy_cnt[2]), 32'd1288);
    for (int g = 0; g < 3; g++) begin
      cmp("wr_count", g, 32'(wr_cnt[g]), 32'd160);
      cmp("rd_count", g, 32'(rd_cnt[g]), 32'd160);
    end
    // trigger write launched one edge before the sampling edge -> first src_rd 5 edges after launch
    cmp("first_rd_latency", 0, 32'(first_rd[0] - trig), 32'd4);
    cmp("oam0_byte0", 0, 32'(oam0[0]), 32'h5A);
    cmp("oam0_byte159", 0, 32'(oam0[159]), 32'hC5);

    // echo remap
    clear_counts();
    cpu_write(16'hFF46, 8'hF1);
    repeat (10) @(negedge clk);
    cpu_read_check(8'hF1);
    wait_idle(3000);
    cmp("echo_first_addr", 0, 32'(first_src_addr), 32'hD100);
    cmp("echo_last_addr", 0, 32'(last_src_addr), 32'hD19F);

    // restart after 50 bytes
    clear_counts();
    cpu_write(16'hFF46, 8'hC0);
    wait_writes(50, 1000);
    cpu_write(16'hFF46, 8'hD0);
    wait_idle(3000);
    cmp("restart_writes", 0, 32'(wr_cnt[0]), 32'd210);
    cmp("restart_oam49", 0, 32'(oam0[49]), 32'h61);
    cmp("restart_oam159", 0, 32'(oam0[159]), 32'hCF);
    cpu_read_check(8'hD0);

    // reset at byte 80
    clear_counts();
    cpu_write(16'hFF46, 8'hC0);
    wait_writes(80, 1000);
    #1;
    reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      cmp("reset_mid_busy", g, 32'(g == 0 ? u[0].busy : (g == 1 ? u[1].busy : u[2].busy)), 32'd0);
    end
    cmp("reset_mid_strobes", 0, 32'({u[0].src_rd, u[0].oam_wr, u[1].src_rd, u[1].oam_wr, u[2].src_rd, u[2].oam_wr}), 32'd0);
    cpu_read_check(8'h00);
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
    repeat (60) @(negedge clk);
    cmp("post_reset_strobes", 0, 32'(wr_cnt[0] + rd_cnt[0] + wr_cnt[1] + rd_cnt[1] + wr_cnt[2] + rd_cnt[2]), 32'd0);

    // randomized triggers, restarts and unrelated CPU traffic
    for (int it = 0; it < 25; it++) begin
      logic [7:0] v;
      int gap;
      v = ($urandom_range(0, 9) < 8) ? vals[$urandom_range(0, 7)] : 8'($urandom);
      cpu_write(16'hFF46, v);
      gap = $urandom_range(0, 1400);
      for (int c = 0; c < gap; c++) begin
        cpu_addr  = 16'($urandom);
        if (cpu_addr == 16'hFF46) cpu_addr = 16'hFF47;
        cpu_wdata = 8'($urandom);
        cpu_wr    = ($urandom_range(0, 7) == 0);
        cpu_rd    = $urandom_range(0, 1);
        @(negedge clk);
      end
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      if ($urandom_range(0, 3) == 0) cpu_read_check(reg_exp);
    end
    wait_idle(3000);
    cpu_read_check(reg_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
